// File: rtl/lfsr_checker.sv
// Galois-LFSR sequence checker: acquires lock on a received LFSR stream, then
// flywheels its own reference and counts words that disagree with it.
module lfsr_checker #(
   parameter TAPS = 8'b11101,
   parameter bit INVERT = 1'b0,
   parameter int unsigned LOCK_COUNT = 16,
   parameter int unsigned UNLOCK_ERRS = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     valid,
   input  logic [$bits(TAPS)-1:0]   din,
   input  logic                     clear_counts,
   output logic                     locked,
   output logic                     error,
   output logic [15:0]              err_count
);

   localparam int NBits  = $bits(TAPS);
   localparam int MatchW = $clog2(LOCK_COUNT + 1);
   localparam int ErrW   = $clog2(UNLOCK_ERRS + 1);

   localparam logic [NBits-1:0]  TapMask   = NBits'(TAPS);
   localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
   localparam logic [ErrW-1:0]   ErrLast   = ErrW'(UNLOCK_ERRS - 1);

   typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

   state_e              state_q, state_d;
   logic [NBits-1:0]    ref_q, ref_d;
   logic [MatchW-1:0]   match_q, match_d;
   logic [ErrW-1:0]     errs_q, errs_d;
   logic                error_d;
   logic [15:0]         cnt_d;
   logic [NBits-1:0]    pred_ref;
   logic                din_match;
   logic                din_fixed;

   function automatic logic [NBits-1:0] pred(input logic [NBits-1:0] x);
      logic [NBits-1:0] sh;
      sh = {x[NBits-2:0], 1'b0};
      return (x[NBits-1] ^ INVERT) ? (sh ^ TapMask) : sh;
   endfunction

   assign pred_ref  = pred(ref_q);
   assign din_match = (din == pred_ref);
   // A fixed point of the step function carries no sequence information.
   assign din_fixed = (pred(din) == din);

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      match_d = match_q;
      errs_d  = errs_q;
      error_d = 1'b0;
      if (valid) begin
         case (state_q)
            StHunt: begin
               if (!din_fixed) begin
                  ref_d   = din;
                  match_d = '0;
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (din_match) begin
                  ref_d   = din;
                  match_d = match_q + 1'b1;
                  if (match_q == MatchLast) begin
                     state_d = StLocked;
                  end
               end else if (din_fixed) begin
                  match_d = '0;
                  state_d = StHunt;
               end else begin
                  ref_d   = din;
                  match_d = '0;
               end
            end
            StLocked: begin
               // Flywheel: the reference never reloads from din once locked.
               ref_d = pred_ref;
               if (din_match) begin
                  errs_d = '0;
               end else begin
                  error_d = 1'b1;
                  errs_d  = errs_q + 1'b1;
                  if (errs_q == ErrLast) begin
                     errs_d  = '0;
                     match_d = '0;
                     state_d = StHunt;
                  end
               end
            end
            default: begin
               state_d = StHunt;
            end
         endcase
      end

      cnt_d = err_count;
      if (clear_counts) begin
         cnt_d = '0;
      end else if (error_d && (err_count != 16'hFFFF)) begin
         cnt_d = err_count + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StHunt;
         ref_q     <= '0;
         match_q   <= '0;
         errs_q    <= '0;
         locked    <= 1'b0;
         error     <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         ref_q     <= ref_d;
         match_q   <= match_d;
         errs_q    <= errs_d;
         locked    <= (state_d == StLocked);
         error     <= error_d;
         err_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference model predicts locked/error/err_count
// per driven cycle and a monitor compares them one cycle later.
module tb_lfsr_checker;

   logic        clk;
   logic        reset_n;
   logic        valid;
   logic [7:0]  din;
   logic        clear_counts;
   logic        locked;
   logic        error;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;

   logic [17:0] exp_q[$];

   lfsr_checker dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid        (valid),
      .din          (din),
      .clear_counts (clear_counts),
      .locked       (locked),
      .error        (error),
      .err_count    (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: 0 = hunting, 1 = verifying, 2 = locked.
   int          m_mode  = 0;
   logic [7:0]  m_ref   = 8'h00;
   int          m_match = 0;
   int          m_errs  = 0;
   int          m_cnt   = 0;
   bit          m_lock  = 1'b0;
   bit          m_err   = 1'b0;

   function automatic logic [7:0] next_word(input logic [7:0] x);
      int t;
      t = (int'(x) * 2) % 256;
      if (int'(x) >= 128) t = t ^ 'h1D;
      return 8'(t);
   endfunction

   task automatic model(input bit v, input logic [7:0] d, input bit clr, input bit rst);
      logic [7:0] e;
      if (rst) begin
         m_mode = 0; m_ref = 8'h00; m_match = 0; m_errs = 0;
         m_cnt = 0; m_lock = 1'b0; m_err = 1'b0;
         return;
      end
      m_err = 1'b0;
      if (v) begin
         if (m_mode == 0) begin
            if (next_word(d) != d) begin
               m_ref = d; m_match = 0; m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (d == next_word(m_ref)) begin
               m_ref = d;
               m_match++;
               if (m_match >= 16) m_mode = 2;
            end else if (next_word(d) == d) begin
               m_mode = 0; m_match = 0;
            end else begin
               m_ref = d; m_match = 0;
            end
         end else begin
            e = next_word(m_ref);
            m_ref = e;
            if (d == e) begin
               m_errs = 0;
            end else begin
               m_err = 1'b1;
               m_errs++;
               if (m_errs >= 4) begin
                  m_mode = 0; m_errs = 0; m_match = 0;
               end
            end
         end
      end
      if (clr) m_cnt = 0;
      else if (m_err && m_cnt < 65535) m_cnt++;
      m_lock = (m_mode == 2);
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit clr, input bit rst);
      @(negedge clk);
      valid        = v;
      din          = d;
      clear_counts = clr;
      reset_n      = !rst;
      model(v, d, clr, rst);
      exp_q.push_back({m_lock, m_err, 16'(m_cnt)});
   endtask

   // Monitor: every output cycle is compared against the oldest prediction.
   initial begin
      logic [17:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (locked !== e[17]) begin
               errors++;
               $display("FAIL locked: got %b expected %b at %0t", locked, e[17], $time);
            end
            checks++;
            if (error !== e[16]) begin
               errors++;
               $display("FAIL error: got %b expected %b at %0t", error, e[16], $time);
            end
            checks++;
            if (err_count !== e[15:0]) begin
               errors++;
               $display("FAIL err_count: got %h expected %h at %0t", err_count, e[15:0], $time);
            end
         end
      end
   end

   logic [7:0] g;

   task automatic send_good();
      drive(1'b1, g, 1'b0, 1'b0);
      g = next_word(g);
   endtask

   task automatic send_bad(input bit clr);
      logic [7:0] flip;
      flip = 8'($urandom_range(1, 255));
      drive(1'b1, g ^ flip, clr, 1'b0);
      g = next_word(g);
   endtask

   task automatic maybe_idle();
      if ($urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   task automatic relock();
      g = 8'($urandom_range(1, 255));
      repeat (17) begin
         maybe_idle();
         send_good();
      end
   endtask

   initial begin
      logic [7:0] b;
      reset_n = 1'b0; valid = 1'b0; din = 8'h00; clear_counts = 1'b0;

      // Reset overrides valid traffic.
      repeat (2) drive(1'b1, 8'h55, 1'b0, 1'b1);

      // Acquire from 0x01, with idle gaps.
      g = 8'h01;
      repeat (17) begin
         maybe_idle();
         send_good();
      end

      // Single corrupted word while locked, then clean words.
      send_bad(1'b0);
      repeat (3) send_good();

      // Four consecutive bad words drop lock; then relock.
      repeat (4) send_bad(1'b0);
      repeat (17) send_good();

      // Unlock again, feed the fixed point, then restart verification after a bad word.
      repeat (4) send_bad(1'b0);
      repeat (5) drive(1'b1, 8'h00, 1'b0, 1'b0);
      g = 8'($urandom_range(1, 255));
      repeat (6) send_good();
      do b = 8'($urandom_range(1, 255)); while (b == g);
      drive(1'b1, b, 1'b0, 1'b0);
      g = next_word(b);
      repeat (15) send_good();
      repeat (3) send_good();

      // Reset mid-verify and mid-lock.
      g = 8'h5A;
      repeat (5) send_good();
      drive(1'b1, g, 1'b0, 1'b1);
      relock();
      send_good();
      drive(1'b1, g, 1'b0, 1'b1);
      drive(1'b1, next_word(g), 1'b0, 1'b0);

      // Randomised traffic mix.
      relock();
      repeat (400) begin
         case ($urandom_range(0, 9))
            0: drive(1'b0, 8'($urandom), 1'b0, 1'b0);
            1: send_bad(1'b0);
            2: drive(1'b1, 8'($urandom), $urandom_range(0, 5) == 0, 1'b0);
            default: begin
               drive(1'b1, g, $urandom_range(0, 15) == 0, 1'b0);
               g = next_word(g);
            end
         endcase
         if (m_mode != 2 && $urandom_range(0, 7) == 0) relock();
      end

      // Saturation: 3 bad + 1 good keeps lock while accumulating errors.
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      g = 8'h01;
      repeat (17) send_good();
      repeat (21845) begin
         repeat (3) send_bad(1'b0);
         send_good();
      end
      send_bad(1'b0);
      send_good();
      send_bad(1'b1);
      send_good();
      send_bad(1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter TAPS, default 8'b11101: Galois tap bitmask; NBITS = bit width of TAPS (8 by default).
REQ-002 SHALL have parameter INVERT, default 0: feedback inversion, identical meaning to the LFSR generator.
REQ-003 SHALL have parameter LOCK_COUNT, default 16: consecutive matching words needed to lock.
REQ-004 SHALL have parameter UNLOCK_ERRS, default 4: consecutive mismatching words, while locked, that drop lock.
REQ-005 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port valid, input, 1: din carries a word this cycle.
REQ-008 SHALL have port din, input, NBITS: received LFSR state word, one generator step per valid word.
REQ-009 SHALL have port clear_counts, input, 1: synchronous zeroing of err_count.
REQ-010 SHALL have port locked, output, 1: checker is synchronised to the sequence.
REQ-011 SHALL have port error, output, 1: one-cycle pulse for a mismatched word while locked.
REQ-012 SHALL have port err_count, output, 16: saturating count of mismatches while locked.

Function
REQ-013 SHALL compute pred(x) = {x[NBITS-2:0],1'b0} ^ ((x[NBITS-1]^INVERT) ? TAPS : 0), with NBITS-bit arithmetic and no carry.
REQ-014 SHALL hold a reference register ref[NBITS-1:0], a match counter, and a consecutive-error counter.
REQ-015 SHALL implement states HUNT, VERIFY and LOCKED; when valid=0, state, counters and ref SHALL hold.
REQ-016 In HUNT with valid: if pred(din)==din (a fixed point, e.g. 0x00 for INVERT=0), the checker SHALL remain in HUNT; otherwise it SHALL set ref=din, set match count to 0, and go to VERIFY.
REQ-017 In VERIFY with valid and din==pred(ref): ref=din and match count +1; on reaching LOCK_COUNT, the checker SHALL go to LOCKED.
REQ-018 In VERIFY with valid and din!=pred(ref): the checker SHALL reseed using the HUNT rule of REQ-016 (fixed-point din goes to HUNT), with match count 0.
REQ-019 In LOCKED with valid: ref SHALL advance to pred(ref) regardless of din (flywheel; din is never loaded).
REQ-020 In LOCKED, a matching word SHALL clear the consecutive-error counter.
REQ-021 In LOCKED, a mismatching word SHALL assert error for exactly one cycle, increment err_count and increment the consecutive-error counter.
REQ-022 On reaching UNLOCK_ERRS consecutive errors, the checker SHALL go to HUNT, with locked=0 on the same edge.
REQ-023 All outputs SHALL be registered; locked, error and err_count SHALL update on the clock edge that samples the valid word (visible the cycle after).
REQ-024 err_count SHALL saturate at 0xFFFF and never wrap.
REQ-025 If clear_counts and a counted error occur on the same edge, clear SHALL win and err_count SHALL be 0.
REQ-026 error SHALL never assert in HUNT or VERIFY.

Reset
REQ-027 On a clock edge with reset_n=0, the checker SHALL go to HUNT, set locked=0, error=0 and err_count=0, and clear ref and both counters, overriding valid and clear_counts.
REQ-028 Reset asserted mid-operation (VERIFY or LOCKED) SHALL take effect on the next edge with no residual lock.

Verification (defaults: TAPS=0x1D, INVERT=0)
REQ-029 reset_n=0 for 2 cycles with valid=1 and din=0x55 -> locked=0, error=0, err_count=0.
REQ-030 17 valid words 0x01,0x02,0x04,...,0x80,0x1D,0x3A,... -> locked=1 the cycle after the 17th word, error never asserted.
REQ-031 Locked and expecting 0x1D, 0x1C is sent, followed by 0x3A -> a single error pulse, err_count=1, locked stays 1, and no error on 0x3A.
REQ-032 Locked, 4 consecutive wrong words -> err_count=+4, locked=0 after the 4th, then HUNT; 17 correct words relock.
REQ-033 In HUNT, din=0x00 repeated with valid -> stays HUNT, locked=0; in VERIFY, one bad word resets progress so that 16 further matches are needed.
REQ-034 err_count preloaded to 0xFFFF by errors -> an extra error keeps 0xFFFF; clear_counts together with an error -> 0.
